// File: rtl/mem_arb_pkg.sv
// Shared defaults and types for the memory arbiter slice.
// Optional build macro MEM_ARB_FIXED_PRIO_EN switches arbitration to fixed priority.
package mem_arb_pkg;

    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_ADDR_W  = 2;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_RD_LAT  = 1;

    // Requester-ID width: ceil(log2(n)), never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [id_width(DEF_NUM_REQ)-1:0] req_id_t;

    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Requester selection: round-robin from i_ptr+1 with wrap, or lowest index
// first when MEM_ARB_FIXED_PRIO_EN is defined (i_ptr is then ignored).
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int ID_W   = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    int                 w_cand;
    logic [NUM_REQ-1:0] w_bits;

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;
`endif

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = 0;
        w_bits  = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = k;
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = (int'(i_ptr) + k) % NUM_REQ;
`endif
            w_bits = i_req >> w_cand;
            if (!o_any && w_bits[0]) begin
                o_any   = 1'b1;
                o_grant = NUM_REQ'(1) << w_cand;
                o_idx   = ID_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between NUM_REQ requesters and routes read data
// back to the issuer. Build macro MEM_ARB_FIXED_PRIO_EN selects fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RD_LAT  = DEF_RD_LAT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_wr_en,
    output logic                      mem_rd_en,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int ID_W = id_width(NUM_REQ);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } sel_req_t;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic [ID_W-1:0]    w_ptr;
    logic [NUM_REQ-1:0] w_wr_bits;
    sel_req_t           w_sel;
    logic               w_acc_wr;
    logic               w_acc_rd;

    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_wr_en;
    logic               r_mem_rd_en;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic [RD_LAT:0]    r_trk_vld;
    logic [ID_W-1:0]    r_trk_id [0:RD_LAT];

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [ID_W-1:0] r_ptr;
    assign w_ptr = r_ptr;

    // Reset value NUM_REQ-1 makes requester 0 the first candidate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= ID_W'(NUM_REQ - 1);
        end else if (w_any) begin
            r_ptr <= w_idx;
        end
    end
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (w_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign req_ready = w_grant;
    assign w_wr_bits = req_write >> w_idx;

    always_comb begin
        w_sel.write = w_wr_bits[0];
        w_sel.addr  = ADDR_W'(req_addr >> (int'(w_idx) * ADDR_W));
        w_sel.wdata = DATA_W'(req_wdata >> (int'(w_idx) * DATA_W));
    end

    assign w_acc_wr = w_any & w_sel.write;
    assign w_acc_rd = w_any & ~w_sel.write;

    // Stage p0: memory-side command registers, driven for exactly one cycle per grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_addr  <= '0;
            r_mem_wr_en <= 1'b0;
            r_mem_rd_en <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_wr_en <= w_acc_wr;
            r_mem_rd_en <= w_acc_rd;
            if (w_any) begin
                r_mem_addr  <= w_sel.addr;
                r_mem_wdata <= w_sel.wdata;
            end
        end
    end

    // Read tracker: stage RD_LAT lines up with mem_rdata becoming valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_trk_vld   <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            for (int j = 0; j <= RD_LAT; j++) begin
                r_trk_id[j] <= '0;
            end
        end else begin
            r_trk_vld   <= {r_trk_vld[RD_LAT-1:0], w_acc_rd};
            r_trk_id[0] <= w_idx;
            for (int j = 1; j <= RD_LAT; j++) begin
                r_trk_id[j] <= r_trk_id[j-1];
            end
            r_rsp_valid <= r_trk_vld[RD_LAT] ? (NUM_REQ'(1) << r_trk_id[RD_LAT]) : '0;
            if (r_trk_vld[RD_LAT]) begin
                r_rsp_rdata <= mem_rdata;
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wr_en = r_mem_wr_en;
    assign mem_rd_en = r_mem_rd_en;
    assign mem_wdata = r_mem_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 4x8 memory between NUM_REQ requesters (drivers or other agents) using a valid/ready request channel and a read-response channel.
- Round-robin arbitration, at most one access per cycle, registered memory-side outputs.
- Tracks in-flight reads so each read response returns to the requester that issued it.
- Sits between the requesters and the memory DUT pins (addr, wr_en, rd_en, wdata, rdata).

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 2, memory address width.
- DATA_W, 8, memory data width.
- RD_LAT, 1, memory read latency in cycles (1..4); rdata is valid RD_LAT edges after the cycle in which rd_en is high.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_write  input  NUM_REQ  1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice i.
- req_wdata  input  NUM_REQ*DATA_W  packed write data.
- req_ready  output  NUM_REQ  grant; one-hot or zero.
- rsp_valid  output  NUM_REQ  read-data valid, one-hot or zero.
- rsp_rdata  output  DATA_W  read data, broadcast to all requesters.
- mem_addr  output  ADDR_W  to memory addr.
- mem_wr_en  output  1  to memory wr_en.
- mem_rd_en  output  1  to memory rd_en.
- mem_wdata  output  DATA_W  to memory wdata.
- mem_rdata  input  DATA_W  from memory rdata.

Behaviour:
- Reset (reset=0, asynchronous) forces the following, independent of clk:
  - mem_addr=0, mem_wr_en=0, mem_rd_en=0, mem_wdata=0.
  - rsp_valid=0, rsp_rdata=0.
  - RR pointer = NUM_REQ-1, so requester 0 wins first.
  - In-flight tracker cleared.
- Reset mid-operation: outstanding reads are discarded; no rsp_valid after reset releases.
- Arbitration is combinational each cycle:
  - The winner is the first requester with req_valid=1, searching upward from pointer+1 with wrap.
  - req_ready is high only for the winner.
  - req_ready never depends on req_ready itself.
- Acceptance occurs when req_valid[i] & req_ready[i] at edge A:
  - The pointer updates to i at edge A.
  - Memory outputs load at edge A, so mem_wr_en or mem_rd_en is high for exactly cycle A+1.
  - mem_addr and mem_wdata hold the accepted values during cycle A+1.
  - mem_wr_en and mem_rd_en are never both high.
- With no acceptance, mem_wr_en and mem_rd_en are 0 the next cycle; mem_addr and mem_wdata hold their last values.
- Throughput: one access per cycle; back-to-back grants are allowed, including to the same requester when it is the only one valid.
- Read tracking:
  - A valid+ID shift pipeline of depth RD_LAT+1 carries the requester ID of each read.
  - mem_rdata is sampled at edge A+1+RD_LAT.
  - rsp_valid[id]=1 and rsp_rdata=sample during cycle A+2+RD_LAT, for one cycle.
  - With RD_LAT=1, read latency is 3 cycles from acceptance.
- Writes produce no response; acceptance is the completion.
- Ordering: accesses reach memory in grant order. Read-after-write to the same address (any requester) returns the new data.
- Unselected requesters must hold req_* stable while valid. The block does not check this.
- Idle: req_valid all 0 gives req_ready=0, and the pointer is unchanged.

Optional Feature:
- Macro MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The pointer register is removed and the winner is the lowest valid index.
- Undefined (default): round-robin as above.
- Response path and latency are identical in both modes.

Decomposition:
- Package mem_arb_pkg holds:
  - Default ADDR_W/DATA_W/RD_LAT constants.
  - Requester-ID typedef (width $clog2(NUM_REQ), minimum 1).
  - Request struct {write, addr, wdata}.
- One sub-module rr_arbiter: req vector plus pointer in, one-hot grant plus encoded index out. It contains the MEM_ARB_FIXED_PRIO_EN selection.
- The top level holds the memory-output registers and the read-tracking pipeline.

Test Plan:
- Req0 writes 0xA5 to addr 2, then reads addr 2 (RD_LAT=1) -> mem_wr_en high the cycle after the write grant; rsp_valid[0]=1 with rsp_rdata=0xA5 exactly 3 cycles after read acceptance; rsp_valid[1] stays 0.
- Both requesters valid with reads for 6 cycles -> req_ready sequence 01,10,01,10,01,10 (one-hot); responses return to requesters in matching alternating order.
- Req1 issues back-to-back reads to addrs 0..3 preloaded with 0x10,0x21,0x32,0x43 -> four consecutive rsp_valid[1] cycles carrying those values in order.
- Read accepted, then reset pulsed low 1 cycle later -> all mem_*/rsp_* outputs 0 immediately; no rsp_valid after release; the first post-reset grant goes to requester 0.
- Req0 writes 0x3C to addr 1 and req1 reads addr 1 in the next granted slot -> req1 receives 0x3C.
- Build with MEM_ARB_FIXED_PRIO_EN and both requesters valid for 4 cycles -> req_ready=01 every cycle; requester 1 is granted only after req_valid[0] drops.
